// File: rtl/pdf_checker_pkg.sv
// Shared types and constants for the multi-channel PDF key checker.
// PDF_VERSION_CHECK_EN (see pdf_sig_match) narrows a match to versions 1.0..1.7.
package pdf_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_KEY_W  = 128;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_SIG_W  = 56;
    localparam int DEF_CNT_W  = 48;

    // ASCII "%PDF-1."
    localparam logic [55:0] PDF_SIG = 56'h255044462D312E;

    localparam logic [7:0] VER_MIN = 8'h30;
    localparam logic [7:0] VER_MAX = 8'h37;

endpackage

// File: rtl/pdf_sig_match.sv
// Combinational header compare for one decrypted block.
// With PDF_VERSION_CHECK_EN defined the trailing byte must also be an ASCII digit '0'..'7'.
module pdf_sig_match
    import pdf_checker_pkg::*;
#(
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0] SIG    = SIG_W'(PDF_SIG)
) (
    input  logic [DATA_W-1:0] data,
    output logic              match
);

    logic sig_ok;

    assign sig_ok = (data[DATA_W-1 -: SIG_W] == SIG);

`ifdef PDF_VERSION_CHECK_EN
    logic ver_ok;
    logic unused_low;

    assign ver_ok     = (data[7:0] >= VER_MIN) && (data[7:0] <= VER_MAX);
    assign match      = sig_ok & ver_ok;
    assign unused_low = ^data[DATA_W-SIG_W-1:0];
`else
    logic unused_low;

    assign match      = sig_ok;
    assign unused_low = ^data[DATA_W-SIG_W-1:0];
`endif

endmodule

// File: rtl/pdf_key_checker.sv
// Multi-channel PDF key checker: latches the first candidate key whose block decrypts to "%PDF-1.".
// Build option PDF_VERSION_CHECK_EN (in pdf_sig_match) also requires a version digit '0'..'7'.
//
//  state  | meaning
//  IDLE   | waiting for start, outputs cleared
//  SEARCH | accepting beats, counting candidates
//  FOUND  | winner latched, input refused until clear
module pdf_key_checker
    import pdf_checker_pkg::*;
#(
    parameter int               NUM_CH = DEF_NUM_CH,
    parameter int               KEY_W  = DEF_KEY_W,
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0] SIG    = SIG_W'(PDF_SIG),
    parameter int               CNT_W  = DEF_CNT_W,
    localparam int              CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*KEY_W-1:0]  in_key,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     busy,
    output logic                     found,
    output logic [KEY_W-1:0]         found_key,
    output logic [CH_W-1:0]          found_ch,
    output logic [CNT_W-1:0]         found_idx,
    output logic [CNT_W-1:0]         cand_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                    state;
    logic [NUM_CH-1:0]         match_vec;
    logic [NUM_CH-1:0]         s1_match;
    logic [NUM_CH*KEY_W-1:0]   s1_keys;
    logic [CNT_W-1:0]          s1_base;
    logic                      s1_hit;
    logic                      accept;
    logic [CH_W-1:0]           win_ch;
    logic [KEY_W-1:0]          win_key;
    logic [CNT_W:0]            cnt_sum;
    logic [CNT_W-1:0]          cnt_next;
    logic [CNT_W:0]            idx_sum;
    logic [CNT_W-1:0]          idx_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pdf_sig_match #(
            .DATA_W (DATA_W),
            .SIG_W  (SIG_W),
            .SIG    (SIG)
        ) u_match (
            .data  (in_data[g*DATA_W +: DATA_W]),
            .match (match_vec[g])
        );
    end

    assign s1_hit   = |s1_match;
    assign in_ready = ena & (state == SEARCH) & ~s1_hit;
    assign accept   = in_valid & in_ready;
    assign busy     = (state == SEARCH);

    // Walk from the top channel down so the lowest set bit wins.
    always_comb begin
        win_ch  = '0;
        win_key = s1_keys[KEY_W-1:0];
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (s1_match[c]) begin
                win_ch  = CH_W'(c);
                win_key = s1_keys[c*KEY_W +: KEY_W];
            end
        end
    end

    // Both the running count and the winner index stick at all-ones instead of wrapping.
    always_comb begin
        cnt_sum  = {1'b0, cand_count} + (CNT_W+1)'(NUM_CH);
        cnt_next = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
        idx_sum  = {1'b0, s1_base} + (CNT_W+1)'(win_ch);
        idx_next = idx_sum[CNT_W] ? CNT_MAX : idx_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s1_match   <= '0;
            s1_keys    <= '0;
            s1_base    <= '0;
            cand_count <= '0;
            found      <= 1'b0;
            found_key  <= '0;
            found_ch   <= '0;
            found_idx  <= '0;
        end else if (ena) begin
            if (clear) begin
                state      <= IDLE;
                s1_match   <= '0;
                s1_keys    <= '0;
                s1_base    <= '0;
                cand_count <= '0;
                found      <= 1'b0;
                found_key  <= '0;
                found_ch   <= '0;
                found_idx  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= SEARCH;
                            s1_match   <= '0;
                            cand_count <= '0;
                        end
                    end
                    SEARCH: begin
                        if (s1_hit) begin
                            state     <= FOUND;
                            found     <= 1'b1;
                            found_key <= win_key;
                            found_ch  <= win_ch;
                            found_idx <= idx_next;
                            s1_match  <= '0;
                        end else if (accept) begin
                            s1_match   <= match_vec;
                            s1_keys    <= in_key;
                            s1_base    <= cand_count;
                            cand_count <= cnt_next;
                        end
                    end
                    FOUND: begin
                        state <= FOUND;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
